// File: rtl/n64_controller_responder.sv
// N64 joybus controller-side responder: decodes host commands and answers polls with button state.
// Optional: define N64_INFO_CMD_EN to also answer info (0x00) and reset (0xFF) commands.
module n64_controller_responder #(
    parameter int unsigned CYCLES_PER_US = 10,
    parameter int unsigned RESP_DELAY_US = 2,
    parameter int unsigned RX_TIMEOUT_US = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] buttons,
    input  logic        line_in,
    output logic        line_drive_low,
    output logic        cmd_valid,
    output logic [7:0]  cmd,
    output logic        busy,
    output logic        rx_error
);
    localparam int unsigned CELL    = 4 * CYCLES_PER_US;
    localparam int unsigned RX_TO   = RX_TIMEOUT_US * CYCLES_PER_US;
    localparam int unsigned RESP    = RESP_DELAY_US * CYCLES_PER_US;
    localparam int unsigned MAX_A   = (RX_TO > CELL) ? RX_TO : CELL;
    localparam int unsigned CNT_MAX = (RESP > MAX_A) ? RESP : MAX_A;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_TOP    = CW'(CNT_MAX);
    localparam logic [CW-1:0] SAMPLE_AT  = CW'(2 * CYCLES_PER_US - 1);
    localparam logic [CW-1:0] RX_LAST    = CW'(RX_TO - 1);
    localparam logic [CW-1:0] US_LAST    = CW'(CYCLES_PER_US - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(3 * CYCLES_PER_US - 1);
    localparam logic [CW-1:0] CELL_LAST  = CW'(CELL - 1);
    // The stop-sample cycle already counts as the first turnaround cycle.
    localparam logic [CW-1:0] RESP_LAST  = CW'((RESP >= 2) ? RESP - 2 : 0);

`ifdef N64_INFO_CMD_EN
    // 0x05,0x00,0x02 each MSB first, arranged so bit 0 goes out first.
    localparam logic [23:0] INFO_STREAM = 24'h4000A0;
`endif

    typedef enum logic [2:0] {
        IDLE, RX_BIT, RX_WAIT, TURNAROUND, TX_LOW, TX_HIGH, TX_STOP, WAIT_HIGH
    } state_t;

    state_t state, stateNext;

    logic          lineMeta, lineSync, linePrev, lineFall;
    logic [CW-1:0] cnt, cntNext, cntInc;
    logic [5:0]    bitCnt, bitCntNext;
    logic [7:0]    cmdShift, cmdShiftNext;
    logic [31:0]   txShift, txShiftNext;
    logic [5:0]    txLast, txLastNext;
    logic [7:0]    cmdNext;
    logic          cmdValidNext, rxErrorNext, cmdSupported;
    logic [CW-1:0] lowLast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lineMeta <= 1'b1;
            lineSync <= 1'b1;
            linePrev <= 1'b1;
        end else begin
            lineMeta <= line_in;
            lineSync <= lineMeta;
            linePrev <= lineSync;
        end
    end

    assign lineFall = linePrev & ~lineSync;
    assign cntInc   = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;
    assign lowLast  = txShift[0] ? US_LAST : LONG_LAST;

    always_comb begin
        cmdSupported = (cmdShift == 8'h01);
`ifdef N64_INFO_CMD_EN
        if (cmdShift == 8'h00 || cmdShift == 8'hFF) cmdSupported = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cntInc;
        bitCntNext   = bitCnt;
        cmdShiftNext = cmdShift;
        txShiftNext  = txShift;
        txLastNext   = txLast;
        cmdNext      = cmd;
        cmdValidNext = 1'b0;
        rxErrorNext  = 1'b0;
        case (state)
            IDLE: begin
                cntNext = '0;
                if (lineFall) begin
                    stateNext  = RX_BIT;
                    bitCntNext = '0;
                end
            end
            RX_BIT: begin
                if (cnt == SAMPLE_AT) begin
                    if (bitCnt == 6'd8) begin
                        cntNext = '0;
                        if (!lineSync) begin
                            rxErrorNext = 1'b1;
                            stateNext   = WAIT_HIGH;
                        end else begin
                            cmdNext      = cmdShift;
                            cmdValidNext = 1'b1;
                            stateNext    = cmdSupported ? TURNAROUND : WAIT_HIGH;
                        end
                    end else begin
                        cmdShiftNext = {cmdShift[6:0], lineSync};
                        bitCntNext   = bitCnt + 6'd1;
                        stateNext    = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                if (lineFall) begin
                    stateNext = RX_BIT;
                    cntNext   = '0;
                end else if (cnt >= RX_LAST) begin
                    rxErrorNext = 1'b1;
                    if (!lineSync) begin
                        stateNext = WAIT_HIGH;
                        cntNext   = '0;
                    end else begin
                        rxErrorNext = (bitCnt >= 6'd1) && (bitCnt <= 6'd8);
                        stateNext   = IDLE;
                    end
                end
            end
            TURNAROUND: begin
                if (cmd_valid) begin
                    txShiftNext = buttons;
                    txLastNext  = 6'd31;
`ifdef N64_INFO_CMD_EN
                    if (cmd != 8'h01) begin
                        txShiftNext = {8'h00, INFO_STREAM};
                        txLastNext  = 6'd23;
                    end
`endif
                end
                if (cnt == RESP_LAST) begin
                    stateNext  = TX_LOW;
                    cntNext    = '0;
                    bitCntNext = '0;
                end
            end
            TX_LOW: begin
                if (cnt == lowLast) stateNext = TX_HIGH;
            end
            TX_HIGH: begin
                if (cnt == CELL_LAST) begin
                    cntNext = '0;
                    if (bitCnt == txLast) begin
                        stateNext = TX_STOP;
                    end else begin
                        stateNext   = TX_LOW;
                        bitCntNext  = bitCnt + 6'd1;
                        txShiftNext = {1'b0, txShift[31:1]};
                    end
                end
            end
            TX_STOP: begin
                if (cnt == US_LAST) begin
                    stateNext = WAIT_HIGH;
                    cntNext   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!lineSync)              cntNext   = '0;
                else if (cnt == US_LAST)    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bitCnt    <= '0;
            cmdShift  <= '0;
            txShift   <= '0;
            txLast    <= 6'd31;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            rx_error  <= 1'b0;
        end else begin
            cnt       <= cntNext;
            bitCnt    <= bitCntNext;
            cmdShift  <= cmdShiftNext;
            txShift   <= txShiftNext;
            txLast    <= txLastNext;
            cmd       <= cmdNext;
            cmd_valid <= cmdValidNext;
            rx_error  <= rxErrorNext;
        end
    end

    // Decoded straight from state so reset releases the pad without a clock edge.
    assign line_drive_low = (state == TX_LOW) || (state == TX_STOP);
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_n64_controller_responder.sv
// Directed testbench for n64_controller_responder: host model drives the open-drain line.
module tb_n64_controller_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] buttons;
    logic        hostLow;
    logic        lineIn;
    logic        lineDriveLow;
    logic        cmdValid;
    logic [7:0]  cmd;
    logic        busy;
    logic        rxError;

    int nCmp = 0;
    int nBad = 0;
    int cvCnt = 0;
    int reCnt = 0;
    int drvCnt = 0;

    always #5 clk = ~clk;

    // Open-drain line with pull-up.
    assign lineIn = ~(hostLow | lineDriveLow);

    n64_controller_responder dut (
        .clk(clk),
        .rst_n(rst_n),
        .buttons(buttons),
        .line_in(lineIn),
        .line_drive_low(lineDriveLow),
        .cmd_valid(cmdValid),
        .cmd(cmd),
        .busy(busy),
        .rx_error(rxError)
    );

    always @(negedge clk) begin
        if (cmdValid === 1'b1) cvCnt++;
        if (rxError === 1'b1) reCnt++;
        if (lineDriveLow === 1'b1) drvCnt++;
    end

    task automatic sendBit(input logic b);
        hostLow = 1'b1;
        repeat (b ? 10 : 30) @(negedge clk);
        hostLow = 1'b0;
        repeat (b ? 30 : 10) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) sendBit(c[i]);
    endtask

    // Stop bit (1 us low); returns ticks from its falling edge to first drive, 0 if none.
    task automatic sendStopWatch(input int limit, output int firstDrive);
        firstDrive = 0;
        hostLow = 1'b1;
        for (int t = 1; t <= limit; t++) begin
            @(negedge clk);
            if (t == 10) hostLow = 1'b0;
            if (lineDriveLow === 1'b1) begin
                firstDrive = t;
                break;
            end
        end
        hostLow = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        for (int t = 0; t < 300 && busy !== 1'b0; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        nCmp++;
        if (busy !== 1'b0) begin
            nBad++;
            $display("FAIL %s_idle: busy=%b want 0", name, busy);
        end
    endtask

    // Called while the first response low sample is current; measures every pulse.
    task automatic checkResponse(input logic [31:0] bits, input int nBits,
                                 input bit toggle, input string name);
        int lo, hi, wantLo;
        for (int i = 0; i <= nBits; i++) begin
            if (toggle && i == 4) buttons = 32'hFFFF_FFFF;
            lo = 1;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (lineDriveLow === 1'b1) lo++;
                else break;
            end
            wantLo = (i == nBits || bits[i]) ? 10 : 30;
            nCmp++;
            if (lo !== wantLo) begin
                nBad++;
                $display("FAIL %s_low[%0d]: got %0d cycles want %0d", name, i, lo, wantLo);
            end
            if (i < nBits) begin
                hi = 1;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (lineDriveLow !== 1'b1) hi++;
                    else break;
                end
                nCmp++;
                if (hi !== 40 - wantLo) begin
                    nBad++;
                    $display("FAIL %s_high[%0d]: got %0d cycles want %0d", name, i, hi, 40 - wantLo);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        hostLow = 1'b0;
        buttons = '0;
        repeat (3) @(negedge clk);
        nCmp++; if (lineDriveLow !== 1'b0) begin nBad++; $display("FAIL reset_drive: got %b want 0", lineDriveLow); end
        nCmp++; if (cmdValid !== 1'b0) begin nBad++; $display("FAIL reset_cmd_valid: got %b want 0", cmdValid); end
        nCmp++; if (cmd !== 8'h00) begin nBad++; $display("FAIL reset_cmd: got %h want 00", cmd); end
        nCmp++; if (busy !== 1'b0) begin nBad++; $display("FAIL reset_busy: got %b want 0", busy); end
        nCmp++; if (rxError !== 1'b0) begin nBad++; $display("FAIL reset_rx_error: got %b want 0", rxError); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        nCmp++; if (busy !== 1'b0) begin nBad++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_poll(input logic [31:0] pat, input bit toggle, input string name);
        int cv0, firstDrive;
        buttons = pat;
        #1 cv0 = cvCnt;
        sendByte(8'h01);
        sendStopWatch(120, firstDrive);
        // 2 sync cycles + sample 2 us into the stop bit + 2 us turnaround
        nCmp++;
        if (firstDrive !== 42) begin
            nBad++;
            $display("FAIL %s_first_edge: got %0d want 42", name, firstDrive);
        end
        checkResponse(pat, 32, toggle, name);
        waitIdle(name);
        #1;
        nCmp++; if (cvCnt - cv0 !== 1) begin nBad++; $display("FAIL %s_cmd_valid_count: got %0d want 1", name, cvCnt - cv0); end
        nCmp++; if (cmd !== 8'h01) begin nBad++; $display("FAIL %s_cmd: got %h want 01", name, cmd); end
    endtask

    task automatic test_unsupported;
        int cv0, drv0;
        logic b32, b33;
        #1 cv0 = cvCnt;
        drv0 = drvCnt;
        sendByte(8'h02);
        hostLow = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (t == 10) hostLow = 1'b0;
            if (t == 32) b32 = busy;
            if (t == 33) b33 = busy;
        end
        #1;
        nCmp++; if (cvCnt - cv0 !== 1) begin nBad++; $display("FAIL unsup_cmd_valid: got %0d want 1", cvCnt - cv0); end
        nCmp++; if (cmd !== 8'h02) begin nBad++; $display("FAIL unsup_cmd: got %h want 02", cmd); end
        nCmp++; if (drvCnt - drv0 !== 0) begin nBad++; $display("FAIL unsup_drive: got %0d cycles want 0", drvCnt - drv0); end
        nCmp++; if (b32 !== 1'b1) begin nBad++; $display("FAIL unsup_busy_hold: got %b want 1", b32); end
        nCmp++; if (b33 !== 1'b0) begin nBad++; $display("FAIL unsup_busy_drop: got %b want 0", b33); end
    endtask

    task automatic test_info;
        int cv0, drv0, firstDrive;
        #1 cv0 = cvCnt;
        drv0 = drvCnt;
        sendByte(8'h00);
        sendStopWatch(120, firstDrive);
`ifdef N64_INFO_CMD_EN
        nCmp++; if (firstDrive !== 42) begin nBad++; $display("FAIL info_first_edge: got %0d want 42", firstDrive); end
        checkResponse(32'h0040_00A0, 24, 1'b0, "info");
`else
        nCmp++; if (firstDrive !== 0) begin nBad++; $display("FAIL info_no_reply: drive at %0d want none", firstDrive); end
        #1;
        nCmp++; if (drvCnt - drv0 !== 0) begin nBad++; $display("FAIL info_drive: got %0d cycles want 0", drvCnt - drv0); end
`endif
        waitIdle("info");
        #1;
        nCmp++; if (cvCnt - cv0 !== 1) begin nBad++; $display("FAIL info_cmd_valid: got %0d want 1", cvCnt - cv0); end
        nCmp++; if (cmd !== 8'h00) begin nBad++; $display("FAIL info_cmd: got %h want 00", cmd); end
    endtask

    task automatic test_truncated;
        int cv0, re0, drv0;
        #1 cv0 = cvCnt;
        re0 = reCnt;
        drv0 = drvCnt;
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
        repeat (80) @(negedge clk);
        #1;
        nCmp++; if (reCnt - re0 !== 1) begin nBad++; $display("FAIL trunc_rx_error: got %0d pulses want 1", reCnt - re0); end
        nCmp++; if (cvCnt - cv0 !== 0) begin nBad++; $display("FAIL trunc_cmd_valid: got %0d want 0", cvCnt - cv0); end
        nCmp++; if (drvCnt - drv0 !== 0) begin nBad++; $display("FAIL trunc_drive: got %0d want 0", drvCnt - drv0); end
        nCmp++; if (busy !== 1'b0) begin nBad++; $display("FAIL trunc_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_stuck_low;
        int re0, errAt;
        logic b111, b112;
        errAt = 0;
        #1 re0 = reCnt;
        hostLow = 1'b1;
        for (int t = 1; t <= 130; t++) begin
            @(negedge clk);
            if (rxError === 1'b1 && errAt == 0) errAt = t;
            if (t == 100) hostLow = 1'b0;
            if (t == 111) b111 = busy;
            if (t == 112) b112 = busy;
        end
        #1;
        // 2 sync + 1 edge detect + 80-cycle timeout
        nCmp++; if (errAt !== 83) begin nBad++; $display("FAIL stuck_err_time: got %0d want 83", errAt); end
        nCmp++; if (reCnt - re0 !== 1) begin nBad++; $display("FAIL stuck_err_count: got %0d want 1", reCnt - re0); end
        nCmp++; if (b111 !== 1'b1) begin nBad++; $display("FAIL stuck_busy_hold: got %b want 1", b111); end
        nCmp++; if (b112 !== 1'b0) begin nBad++; $display("FAIL stuck_busy_drop: got %b want 0", b112); end
    endtask

    task automatic test_reset_during_tx;
        int firstDrive;
        buttons = 32'h0000_0000;
        sendByte(8'h01);
        sendStopWatch(120, firstDrive);
        repeat (5) @(negedge clk);
        nCmp++; if (lineDriveLow !== 1'b1) begin nBad++; $display("FAIL rst_tx_precond: drive=%b want 1", lineDriveLow); end
        #2 rst_n = 1'b0;
        #1;
        nCmp++; if (lineDriveLow !== 1'b0) begin nBad++; $display("FAIL rst_tx_release: drive=%b want 0", lineDriveLow); end
        nCmp++; if (busy !== 1'b0) begin nBad++; $display("FAIL rst_tx_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_poll(32'h8000_0001, 1'b0, "poll");
        repeat (20) @(negedge clk);
        test_poll(32'h1234_5678, 1'b1, "latch");
        repeat (20) @(negedge clk);
        test_unsupported();
        repeat (20) @(negedge clk);
        test_info();
        repeat (20) @(negedge clk);
        test_truncated();
        repeat (20) @(negedge clk);
        test_stuck_low();
        repeat (20) @(negedge clk);
        test_reset_during_tx();
        test_poll(32'hA5A5_0F0F, 1'b0, "after_rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
